mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-access stage of the 16-bit pipeline, between the EX/MEM register and the MEM/WB register. Non-memory instructions pass straight through to the MEM/WB inputs in the same cycle. Loads and stores run a handshaked request on the data-memory port, stall upstream stages until completion, and then present the finished instruction (with load data) to MEM/WB. A per-access timeout prevents a dead memory from hanging the pipeline.

## Interface
Parameters:
- TIMEOUT, 255, maximum ACCESS cycles before forced completion; 0 disables the timeout. Counter width is 8 bits; legal range is 0..255.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX/MEM holds a valid instruction.
- ex_alu_result  input  16  ALU result, used as the byte-agnostic word address for memory ops.
- ex_write_data  input  16  store data.
- ex_rd  input  4  destination register.
- ex_mem_read  input  1  load.
- ex_mem_write  input  1  store; has priority over ex_mem_read when both are set.
- ex_reg_write  input  1  writeback enable.
- ex_mem_to_reg  input  1  writeback selects memory data.
- mem_alu_result  output  16  to MEM/WB.
- mem_read_data  output  16  to MEM/WB.
- mem_rd  output  4  to MEM/WB.
- mem_reg_write  output  1  to MEM/WB.
- mem_mem_to_reg  output  1  to MEM/WB.
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- dmem_req  output  1  memory request, decoded from the state register.
- dmem_we  output  1  1 = write.
- dmem_addr  output  16  latched address.
- dmem_wdata  output  16  latched store data.
- dmem_ready  input  1  memory completes the request this cycle.
- dmem_rdata  input  16  load data; valid when dmem_ready=1.
- mem_fault  output  1  sticky; set on timeout, cleared only by rst.

## Operation
- A memory op is ex_valid & (ex_mem_read | ex_mem_write).
- Bubble means mem_alu_result=0, mem_read_data=0, mem_rd=0, mem_reg_write=0, mem_mem_to_reg=0.

States: IDLE and ACCESS.

IDLE:
- ex_valid=0: outputs are a bubble; mem_stall=0.
- Non-memory op: outputs equal the ex_* fields combinationally; mem_read_data=0; mem_stall=0.
- Memory op:
  - Latch the address, write data, rd, reg_write, mem_to_reg, and we=ex_mem_write.
  - Clear the timeout counter and go to ACCESS.
  - This cycle: outputs are a bubble and mem_stall=1.

ACCESS:
- dmem_req=1; dmem_we, dmem_addr and dmem_wdata come from the latches. Changes on ex_* inputs are ignored.
- dmem_ready=0 and counter < TIMEOUT-1 (or TIMEOUT=0):
  - Counter increments.
  - Outputs are a bubble; mem_stall=1.
- dmem_ready=1 (completion):
  - Outputs carry the latched fields.
  - mem_read_data = dmem_rdata for a load, 0 for a store.
  - mem_stall=0; next state is IDLE.
- Timeout (dmem_ready=0 and counter = TIMEOUT-1):
  - Completes exactly like dmem_ready=1, except mem_read_data=0.
  - mem_fault is set on the next edge; next state is IDLE.
- dmem_ready is ignored in IDLE.
- When both ex_mem_read and ex_mem_write are set, the op is a store: dmem_we=1 and mem_read_data=0.

## Timing
- Non-memory op: 0 extra cycles, no stall.
- Memory op: minimum 2 cycles (accept cycle + one ACCESS cycle with ready). The general cost is 1 + N cycles, where N is the number of ACCESS cycles up to and including the ready cycle. Stall is asserted for all but the last cycle.
- With TIMEOUT=T>0, ACCESS lasts at most T cycles.
- Back-to-back memory ops: the cycle after completion is IDLE, which accepts the next op. The dmem_req gap is 1 cycle.
- Reset:
  - While rst is high, all outputs are forced to 0 (bubble, mem_stall=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0).
  - On the edge with rst high: state=IDLE, counter=0, latches=0, mem_fault=0.
  - Reset in ACCESS abandons the request. No completion is emitted.

## Test plan
- Reset: hold rst 2 cycles mid-ACCESS -> dmem_req=0, mem_stall=0, all outputs 0 during and after reset; mem_fault=0.
- ALU op rd=3, result=16'h1234, reg_write=1 -> same-cycle mem_alu_result=16'h1234, mem_rd=3, mem_reg_write=1, mem_stall=0.
- Load addr=16'h0040, ready returned on the 3rd ACCESS cycle with rdata=16'hBEEF:
  - mem_stall=1 for 3 cycles.
  - Completion cycle: mem_read_data=16'hBEEF, mem_mem_to_reg=1, mem_alu_result=16'h0040.
  - dmem_req high for exactly 3 cycles.
- Store addr=16'h0010, data=16'h00AA, ready on the first ACCESS cycle:
  - dmem_we=1, dmem_wdata=16'h00AA.
  - 2-cycle op; completion has mem_reg_write=0 and mem_read_data=0.
- TIMEOUT=4, load, ready never asserted:
  - dmem_req high 4 cycles.
  - Completion on the 4th with mem_read_data=0.
  - mem_fault=1 from the next cycle and stays set until rst.
- Load then ALU op back-to-back, with ex_* changed during ACCESS:
  - Latched load values are used.
  - The ALU op passes through the cycle after load completion.
  - ex_mem_read & ex_mem_write both set -> dmem_we=1.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-access pipeline stage with handshaked data port and access timeout
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_alu_result,
    input  logic [15:0] ex_write_data,
    input  logic [3:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    output logic [15:0] mem_alu_result,
    output logic [15:0] mem_read_data,
    output logic [3:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_to_reg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [15:0] dmem_rdata,
    output logic        mem_fault
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] addr_q, wdata_q;
    logic [3:0]  rd_q;
    logic        reg_write_q, mem_to_reg_q, we_q;
    logic [7:0]  cnt_q;
    logic        fault_q;

    logic mem_op, timed_out, done;

    assign mem_op    = ex_valid & (ex_mem_read | ex_mem_write);
    assign timed_out = (TIMEOUT != 0) && !dmem_ready && (cnt_q == LAST_CNT);
    assign done      = dmem_ready | timed_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op) state_nxt = ACCESS;
            ACCESS:  if (done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Store wins over load when both flags are set, so we is simply ex_mem_write.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
        end else begin
            if (state == IDLE && mem_op) begin
                addr_q       <= ex_alu_result;
                wdata_q      <= ex_write_data;
                rd_q         <= ex_rd;
                reg_write_q  <= ex_reg_write;
                mem_to_reg_q <= ex_mem_to_reg;
                we_q         <= ex_mem_write;
                cnt_q        <= '0;
            end else if (state == ACCESS && !done) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state == ACCESS && timed_out) begin
                fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_alu_result = '0;
        mem_read_data  = '0;
        mem_rd         = '0;
        mem_reg_write  = 1'b0;
        mem_mem_to_reg = 1'b0;
        mem_stall      = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        mem_fault      = 1'b0;
        if (!rst) begin
            mem_fault  = fault_q;
            dmem_addr  = addr_q;
            dmem_wdata = wdata_q;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        mem_stall = 1'b1;
                    end else if (ex_valid) begin
                        mem_alu_result = ex_alu_result;
                        mem_rd         = ex_rd;
                        mem_reg_write  = ex_reg_write;
                        mem_mem_to_reg = ex_mem_to_reg;
                    end
                end
                ACCESS: begin
                    dmem_req = 1'b1;
                    dmem_we  = we_q;
                    if (done) begin
                        mem_alu_result = addr_q;
                        mem_rd         = rd_q;
                        mem_reg_write  = reg_write_q;
                        mem_mem_to_reg = mem_to_reg_q;
                        mem_read_data  = (dmem_ready && !we_q) ? dmem_rdata : 16'h0000;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
